// File: rtl/pc_fetch_unit.sv
// Program-counter and fetch sequencer: issues fetches, presents instructions to decode, squashes after redirects.
// Optional trace outputs (redirect_count, last_redirect_src) are built when PC_FETCH_TRACE_EN is defined.
module pc_fetch_unit #(
   parameter int                ADDR_W      = 16,
   parameter int                INSTR_W     = 32,
   parameter logic [ADDR_W-1:0] RESET_VEC   = {ADDR_W{1'b0}},
   parameter int                FLUSH_DEPTH = 2
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [ADDR_W-1:0]  jmp_loc,
   input  logic               pc_mux_sel,
   input  logic               stall,
   input  logic               fetch_ack,
   input  logic [INSTR_W-1:0] instr_in,
   output logic               fetch_req,
   output logic [ADDR_W-1:0]  fetch_addr,
   output logic [INSTR_W-1:0] instr_out,
   output logic               instr_valid,
   output logic [ADDR_W-1:0]  current_address,
   output logic               flush
`ifdef PC_FETCH_TRACE_EN
   ,
   output logic [15:0]        redirect_count,
   output logic [ADDR_W-1:0]  last_redirect_src
`endif
);

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      FETCH = 2'd1,
      HOLD  = 2'd2,
      FLUSH = 2'd3
   } state_t;

   localparam logic [2:0]        FLUSH_CNT = 3'(FLUSH_DEPTH);
   localparam logic [ADDR_W-1:0] PC_ONE    = {{(ADDR_W-1){1'b0}}, 1'b1};

   state_t               state_r, state_s;
   logic [ADDR_W-1:0]    pc_r, pc_s;
   logic                 req_r, req_s;
   logic [INSTR_W-1:0]   instr_r, instr_s;
   logic                 valid_r, valid_s;
   logic [ADDR_W-1:0]    cur_r, cur_s;
   logic                 flush_r, flush_s;
   logic [2:0]           cnt_r, cnt_s;
   logic                 redirect_s;
   logic                 accept_s;

   // Next-state and next-output logic; a redirect overrides whatever the per-state branch chose
   always_comb begin
      state_s    = state_r;
      pc_s       = pc_r;
      req_s      = req_r;
      instr_s    = instr_r;
      valid_s    = valid_r;
      cur_s      = cur_r;
      flush_s    = flush_r;
      cnt_s      = cnt_r;
      accept_s   = 1'b0;
      redirect_s = pc_mux_sel && (state_r != BOOT);

      case (state_r)
         BOOT: begin
            state_s = FETCH;
            req_s   = 1'b1;
         end
         FETCH: begin
            if (stall) begin
               req_s   = 1'b0;
               state_s = valid_r ? HOLD : FETCH;
            end else begin
               req_s    = 1'b1;
               accept_s = fetch_ack;
               valid_s  = 1'b0;
            end
         end
         HOLD: begin
            if (stall) begin
               state_s = HOLD;
            end else begin
               state_s  = FETCH;
               req_s    = 1'b1;
               accept_s = fetch_ack;
               valid_s  = 1'b0;
            end
         end
         FLUSH: begin
            if (cnt_r <= 3'd1) begin
               state_s = FETCH;
               req_s   = 1'b1;
               flush_s = 1'b0;
               cnt_s   = 3'd0;
            end else begin
               cnt_s = cnt_r - 3'd1;
            end
         end
         default: begin
            state_s = BOOT;
            req_s   = 1'b0;
         end
      endcase

      if (redirect_s) begin
         state_s = FLUSH;
         pc_s    = jmp_loc;
         req_s   = 1'b0;
         valid_s = 1'b0;
         flush_s = 1'b1;
         cnt_s   = FLUSH_CNT;
      end else if (accept_s) begin
         instr_s = instr_in;
         valid_s = 1'b1;
         cur_s   = pc_r;
         pc_s    = pc_r + PC_ONE;
      end else begin
         pc_s = pc_r;
      end
   end

   // State and output registers with asynchronous reset
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r <= BOOT;
         pc_r    <= RESET_VEC;
         req_r   <= 1'b0;
         instr_r <= {INSTR_W{1'b0}};
         valid_r <= 1'b0;
         cur_r   <= RESET_VEC;
         flush_r <= 1'b0;
         cnt_r   <= 3'd0;
      end else begin
         state_r <= state_s;
         pc_r    <= pc_s;
         req_r   <= req_s;
         instr_r <= instr_s;
         valid_r <= valid_s;
         cur_r   <= cur_s;
         flush_r <= flush_s;
         cnt_r   <= cnt_s;
      end
   end

   assign fetch_req       = req_r;
   assign fetch_addr      = pc_r;
   assign instr_out       = instr_r;
   assign instr_valid     = valid_r;
   assign current_address = cur_r;
   assign flush           = flush_r;

`ifdef PC_FETCH_TRACE_EN
   logic [15:0]       rcount_r;
   logic [ADDR_W-1:0] rsrc_r;

   // Redirect trace: saturating count and the PC that was abandoned
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rcount_r <= 16'h0000;
         rsrc_r   <= {ADDR_W{1'b0}};
      end else if (redirect_s) begin
         rcount_r <= (rcount_r == 16'hFFFF) ? rcount_r : rcount_r + 16'h0001;
         rsrc_r   <= pc_r;
      end else begin
         rcount_r <= rcount_r;
         rsrc_r   <= rsrc_r;
      end
   end

   assign redirect_count    = rcount_r;
   assign last_redirect_src = rsrc_r;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed scenarios then random traffic against a reference model.
module tb_pc_fetch_unit;

   localparam int D = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] jmp_loc;
   logic        pc_mux_sel;
   logic        stall;
   logic        fetch_ack;
   logic [31:0] instr_in;
   logic        fetch_req;
   logic [15:0] fetch_addr;
   logic [31:0] instr_out;
   logic        instr_valid;
   logic [15:0] current_address;
   logic        flush;
`ifdef PC_FETCH_TRACE_EN
   logic [15:0] redirect_count;
   logic [15:0] last_redirect_src;
`endif

   int checks   = 0;
   int failures = 0;

   // reference model state
   logic [15:0] m_pc, m_cur, m_rcount, m_src;
   logic [31:0] m_instr;
   logic        m_req, m_valid, m_flush, m_boot, m_hold;
   int          m_bub;

   pc_fetch_unit #(
      .ADDR_W(16), .INSTR_W(32), .RESET_VEC(16'h0000), .FLUSH_DEPTH(D)
   ) dut (
      .clk(clk), .reset(reset), .jmp_loc(jmp_loc), .pc_mux_sel(pc_mux_sel),
      .stall(stall), .fetch_ack(fetch_ack), .instr_in(instr_in),
      .fetch_req(fetch_req), .fetch_addr(fetch_addr), .instr_out(instr_out),
      .instr_valid(instr_valid), .current_address(current_address), .flush(flush)
`ifdef PC_FETCH_TRACE_EN
      , .redirect_count(redirect_count), .last_redirect_src(last_redirect_src)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_pc = 16'h0000; m_cur = 16'h0000; m_instr = 32'h0;
      m_req = 1'b0; m_valid = 1'b0; m_flush = 1'b0;
      m_boot = 1'b1; m_hold = 1'b0; m_bub = 0;
      m_rcount = 16'h0000; m_src = 16'h0000;
   endtask

   task automatic model_accept(input logic ack, input logic [31:0] ins);
      if (ack) begin
         m_instr = ins; m_valid = 1'b1; m_cur = m_pc; m_pc = m_pc + 16'd1;
      end else begin
         m_valid = 1'b0;
      end
   endtask

   // one rising edge of the architectural behaviour
   task automatic model_step(input logic sel, input logic [15:0] jmp, input logic stl,
                             input logic ack, input logic [31:0] ins);
      if (m_boot) begin
         m_boot = 1'b0; m_req = 1'b1;
      end else if (sel) begin
         if (m_rcount != 16'hFFFF) m_rcount = m_rcount + 16'd1;
         m_src = m_pc;
         m_pc = jmp; m_valid = 1'b0; m_flush = 1'b1; m_bub = D; m_req = 1'b0; m_hold = 1'b0;
      end else if (m_bub > 0) begin
         if (m_bub == 1) begin
            m_bub = 0; m_flush = 1'b0; m_req = 1'b1;
         end else begin
            m_bub = m_bub - 1;
         end
      end else if (m_hold) begin
         if (!stl) begin
            m_hold = 1'b0; m_req = 1'b1;
            model_accept(ack, ins);
         end
      end else if (stl) begin
         m_req = 1'b0;
         if (m_valid) m_hold = 1'b1;
      end else begin
         m_req = 1'b1;
         model_accept(ack, ins);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".fetch_addr"},      {16'h0, fetch_addr},      {16'h0, m_pc});
      check({tag, ".fetch_req"},       {31'h0, fetch_req},       {31'h0, m_req});
      check({tag, ".instr_valid"},     {31'h0, instr_valid},     {31'h0, m_valid});
      check({tag, ".instr_out"},       instr_out,                m_instr);
      check({tag, ".current_address"}, {16'h0, current_address}, {16'h0, m_cur});
      check({tag, ".flush"},           {31'h0, flush},           {31'h0, m_flush});
`ifdef PC_FETCH_TRACE_EN
      check({tag, ".redirect_count"},    {16'h0, redirect_count},    {16'h0, m_rcount});
      check({tag, ".last_redirect_src"}, {16'h0, last_redirect_src}, {16'h0, m_src});
`endif
   endtask

   // drive at the falling edge, let one rising edge happen, compare at the next falling edge
   task automatic cycle(input logic sel, input logic [15:0] jmp, input logic stl,
                        input logic ack, input logic [31:0] ins);
      pc_mux_sel = sel; jmp_loc = jmp; stall = stl; fetch_ack = ack; instr_in = ins;
      @(posedge clk);
      model_step(sel, jmp, stl, ack, ins);
      @(negedge clk);
      check_all("cyc");
   endtask

   initial begin
      reset = 1'b0; pc_mux_sel = 1'b0; jmp_loc = 16'h0; stall = 1'b0;
      fetch_ack = 1'b0; instr_in = 32'h0;
      model_reset();
      repeat (2) @(negedge clk);
      check_all("reset");
      reset = 1'b1;

      // boot then sequential fetch with ack tied high
      cycle(1'b0, 16'h0, 1'b0, 1'b1, 32'h1000_0000);
      check("boot_req", {31'h0, fetch_req}, 32'h1);
      check("boot_addr", {16'h0, fetch_addr}, 32'h0000);
      for (int i = 1; i <= 5; i++) begin
         cycle(1'b0, 16'h0, 1'b0, 1'b1, 32'h1000_0000 + 32'(i));
         if (i == 1) begin
            check("first_valid", {31'h0, instr_valid}, 32'h1);
            check("first_cur", {16'h0, current_address}, 32'h0000);
         end
      end
      check("pc5", {16'h0, fetch_addr}, 32'h0005);

      // redirect to 0x0008 at pc=5; the ack in the redirect cycle is dropped
      cycle(1'b1, 16'h0008, 1'b0, 1'b1, 32'hBAD0_0005);
      check("redir_flush", {31'h0, flush}, 32'h1);
      check("redir_valid", {31'h0, instr_valid}, 32'h0);
      cycle(1'b0, 16'h0, 1'b0, 1'b1, 32'hBAD0_0006);
      check("flush2", {31'h0, flush}, 32'h1);
      cycle(1'b0, 16'h0, 1'b0, 1'b1, 32'hBAD0_0007);
      check("flush_done", {31'h0, flush}, 32'h0);
      check("target_addr", {16'h0, fetch_addr}, 32'h0008);
      check("no_wrong_path", instr_out, 32'h1000_0005);

      // stall with a valid instruction held for three cycles
      cycle(1'b0, 16'h0, 1'b0, 1'b1, 32'hDEAD_BEEF);
      repeat (3) cycle(1'b0, 16'h0, 1'b1, 1'b1, 32'h5555_5555);
      check("hold_instr", instr_out, 32'hDEAD_BEEF);
      check("hold_cur", {16'h0, current_address}, 32'h0008);
      check("hold_pc", {16'h0, fetch_addr}, 32'h0009);
      check("hold_req", {31'h0, fetch_req}, 32'h0);
      cycle(1'b0, 16'h0, 1'b0, 1'b0, 32'h0);
      check("consumed", {31'h0, instr_valid}, 32'h0);

      // redirect beats stall
      cycle(1'b1, 16'h0100, 1'b1, 1'b1, 32'h7777_7777);
      cycle(1'b0, 16'h0, 1'b0, 1'b0, 32'h0);
      cycle(1'b0, 16'h0, 1'b0, 1'b0, 32'h0);
      check("stall_redir_addr", {16'h0, fetch_addr}, 32'h0100);
      check("stall_redir_req", {31'h0, fetch_req}, 32'h1);

      // wrap from 0xFFFF
      cycle(1'b1, 16'hFFFF, 1'b0, 1'b0, 32'h0);
      repeat (D) cycle(1'b0, 16'h0, 1'b0, 1'b0, 32'h0);
      check("wrap_pre", {16'h0, fetch_addr}, 32'hFFFF);
      cycle(1'b0, 16'h0, 1'b0, 1'b1, 32'hCAFE_F00D);
      check("wrap_addr", {16'h0, fetch_addr}, 32'h0000);
      check("wrap_cur", {16'h0, current_address}, 32'hFFFF);

      // asynchronous reset in the middle of a flush
      cycle(1'b1, 16'h0042, 1'b0, 1'b0, 32'h0);
      cycle(1'b0, 16'h0, 1'b0, 1'b1, 32'h1234_5678);
      reset = 1'b0;
      #2;
      model_reset();
      check_all("async_rst");
      @(negedge clk);
      check_all("rst_hold");
      reset = 1'b1;
      cycle(1'b0, 16'h0, 1'b0, 1'b1, 32'hAAAA_0000);
      check("reboot_req", {31'h0, fetch_req}, 32'h1);
      cycle(1'b0, 16'h0, 1'b0, 1'b1, 32'hAAAA_0001);
      check("reboot_instr", instr_out, 32'hAAAA_0001);

      // random traffic
      for (int n = 0; n < 400; n++) begin
         cycle(($urandom_range(0, 9) == 0), 16'($urandom), ($urandom_range(0, 3) == 0),
               ($urandom_range(0, 9) < 6), $urandom);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Program-counter and fetch sequencer on the consuming side of the jump-control interface.
- Takes jmp_loc/pc_mux_sel from the jump-control block and keeps the architectural PC.
- Issues fetch requests to program memory over a req/ack handshake and presents fetched instructions to decode.
- Returns current_address, the PC of the instruction in decode, to the jump-control block; on a redirect it squashes wrong-path instructions for a fixed number of cycles.

Parameters:
- ADDR_W, 16, PC / address width.
- INSTR_W, 32, instruction width.
- RESET_VEC, 16'h0000, PC value loaded on reset.
- FLUSH_DEPTH, 2, bubble cycles inserted after a redirect; legal range 1..7.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- jmp_loc  in  ADDR_W  redirect target from jump control.
- pc_mux_sel  in  1  1 = load jmp_loc into PC (redirect); 0 = sequential.
- stall  in  1  decode back-pressure; 1 = hold.
- fetch_ack  in  1  memory has instr_in valid for the current fetch_addr.
- instr_in  in  INSTR_W  fetched instruction word.
- fetch_req  out  1  fetch request to program memory.
- fetch_addr  out  ADDR_W  fetch address, equal to PC.
- instr_out  out  INSTR_W  instruction to decode.
- instr_valid  out  1  instr_out is a real instruction.
- current_address  out  ADDR_W  address of instr_out, returned to jump control.
- flush  out  1  high during squash bubbles.

Behaviour:
- Reset (reset=0, asynchronous):
  - pc=RESET_VEC, fetch_addr=RESET_VEC, current_address=RESET_VEC.
  - fetch_req=0, instr_out=0, instr_valid=0, flush=0.
  - state=BOOT, bubble counter=0.
- States:
  - BOOT: one cycle after reset deasserts, then go to FETCH. fetch_req=0.
  - FETCH: fetch_req=1, fetch_addr=pc.
  - HOLD: stall=1 with valid data held. fetch_req=0; instr_out, instr_valid, current_address and pc are frozen.
  - FLUSH: bubble counter counts FLUSH_DEPTH down to 0. instr_valid=0, flush=1, fetch_req=0. Returns to FETCH on the cycle the counter reaches 1.
- FETCH rules, evaluated on each rising edge in this priority order:
  1. pc_mux_sel=1: pc<=jmp_loc; any ack this cycle is discarded; instr_valid<=0; flush<=1; counter<=FLUSH_DEPTH; go to FLUSH.
  2. stall=1: hold everything; go to HOLD if instr_valid=1, otherwise stay in FETCH with fetch_req=0.
  3. fetch_ack=1: instr_out<=instr_in; instr_valid<=1; current_address<=pc; pc<=pc+1.
  4. Otherwise (no ack): instr_valid<=0; pc unchanged; fetch_req stays 1.
- Latency:
  - Ack sampled on edge N gives instr_valid=1 after edge N.
  - Redirect sampled on edge N puts the first target-path fetch_req=1 FLUSH_DEPTH cycles later.
- Arithmetic: pc+1 is modulo 2^ADDR_W. PC 16'hFFFF wraps to 16'h0000 with no flag.
- Redirect in HOLD or FLUSH: pc_mux_sel=1 reloads pc<=jmp_loc and restarts the counter at FLUSH_DEPTH; it overrides stall.
- HOLD exits to FETCH when stall=0; the held instruction is consumed that edge and instr_valid<=0 unless a new ack arrives in the same cycle.
- fetch_addr and fetch_req are registered; there is no combinational path from the inputs to any output.
- Reset asserted mid-fetch or mid-flush aborts immediately to the reset values; outstanding acks are ignored until FETCH.

Optional Feature:
- Macro: PC_FETCH_TRACE_EN.
- When defined:
  - Adds output redirect_count [15:0], reset to 0.
  - Increments by 1 on every accepted redirect and saturates at 16'hFFFF.
  - Adds output last_redirect_src [ADDR_W-1:0], the pc value at the moment of the redirect.
- When undefined: neither port nor their registers exist; all other behaviour is identical.

Test Plan:
- Reset release, fetch_ack tied high → fetch_addr sequence 0000, 0001, 0002; instr_valid first high one cycle after the first ack; current_address tracks each instr_in.
- At pc=0005, pulse pc_mux_sel=1 with jmp_loc=0008, FLUSH_DEPTH=2 → flush high for 2 cycles, instr_valid=0 during the flush, next fetch_addr=0008, no instr_out from the 0005 ack.
- stall=1 for 3 cycles with a valid instruction (instr_in=0xDEADBEEF) → instr_out, current_address and pc frozen, fetch_req=0; the instruction is consumed once after stall drops.
- pc_mux_sel=1 and stall=1 in the same cycle, jmp_loc=0x0100 → redirect wins; fetch_addr=0x0100 after the bubbles.
- Jump to 0xFFFF, then sequential acks → fetch_addr 0xFFFF, then 0x0000.
- reset pulsed low mid-FLUSH → all outputs return to reset values asynchronously; BOOT, then fetch at RESET_VEC; with PC_FETCH_TRACE_EN defined, redirect_count returns to 0.
